// File: rtl/instr_queue_mw_pkg.sv
// Shared helpers for the multi-lane micro-instruction queue.
// Default entry width is supplied here when the global decode-width define is absent.
`ifndef DECODE_INFO_DW
`define DECODE_INFO_DW 32
`endif

package instr_queue_mw_pkg;

    // Number of set bits in a lane-valid vector (lanes are at most 32 wide).
    function automatic int unsigned lane_count(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gen_dffr.sv
// Plain D flip-flop bank with synchronous active-low clear.
// One-cycle latency; no flow control.
module gen_dffr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qout <= '0;
        end else begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/gen_rsffr.sv
// Set/reset flip-flop bank with synchronous active-low clear; reset input beats set.
// One-cycle latency; no flow control.
module gen_rsffr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_in,
    input  logic          rst_in,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (rst_in) begin
            qout <= '0;
        end else if (set_in) begin
            qout <= '1;
        end
    end

endmodule

// File: rtl/queue_lane_sel.sv
// Rotates circular-array entries starting at a base pointer onto LANES output lanes.
// Purely combinational; no flow control.
module queue_lane_sel
    import instr_queue_mw_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 3,
    parameter int LANES = 2
) (
    input  logic [(2**AW)*DW-1:0] entries,
    input  logic [AW:0]           base,
    output logic [LANES*DW-1:0]   lanes
);

    localparam int DEPTH = 2**AW;

    always_comb begin
        int idx;
        idx   = 0;
        lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            // Pointer wrap bit is irrelevant to slot selection; modulo folds it away.
            idx = (int'(base) + i) % DEPTH;
            lanes[i*DW +: DW] = entries[idx*DW +: DW];
        end
    end

endmodule

// File: rtl/instr_queue_mw.sv
// Multi-lane decoded micro-instruction queue with mispredict shadow; pop is zero-latency, push visible next cycle.
// Whole push group is rejected unless PUSH_W slots are free; contents hidden from issue while the shadow flag is set.
module instr_queue_mw
    import instr_queue_mw_pkg::*;
#(
    parameter int DW     = `DECODE_INFO_DW,
    parameter int AW     = 3,
    parameter int PUSH_W = 2,
    parameter int POP_W  = 2
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    input  logic [PUSH_W-1:0]            push_valid,
    input  logic [PUSH_W*DW-1:0]         push_data,
    output logic                         push_reject,
    output logic [POP_W-1:0]             pop_valid,
    output logic [POP_W*DW-1:0]          pop_data,
    input  logic [$clog2(POP_W+1)-1:0]   pop_cnt,
    input  logic                         feflush,
    input  logic                         beflush,
    output logic                         isMisPredict,
    output logic [AW:0]                  count
);

    localparam int DEPTH = 2**AW;
    localparam int PW    = AW + 1;

    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr_nxt;
    logic [PW-1:0]       wr_ptr_nxt;
    logic [PW-1:0]       count_nxt;
    logic [PW-1:0]       npush;
    logic [PW-1:0]       npop;
    logic                flush;
    logic                push_en;
    logic [DW-1:0]       mem [DEPTH];
    logic [DEPTH*DW-1:0] entries;

    assign flush = feflush | beflush;

    // Decided from registered occupancy only, so a same-cycle pop never frees room.
    assign push_reject = (DEPTH - int'(count)) < PUSH_W;
    assign push_en     = ~push_reject & ~flush;

    assign npush = push_en      ? PW'(lane_count(32'(push_valid))) : '0;
    assign npop  = isMisPredict ? '0 : PW'(pop_cnt);

    always_comb begin
        rd_ptr_nxt = rd_ptr + npop;
        wr_ptr_nxt = wr_ptr + npush;
        count_nxt  = count + npush - npop;
        if (flush) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
        end
    end

    gen_dffr #(.DW(PW)) u_rd_ptr (
        .clk   (CLK),
        .rst_n (RSTn),
        .dnxt  (rd_ptr_nxt),
        .qout  (rd_ptr)
    );

    gen_dffr #(.DW(PW)) u_wr_ptr (
        .clk   (CLK),
        .rst_n (RSTn),
        .dnxt  (wr_ptr_nxt),
        .qout  (wr_ptr)
    );

    gen_dffr #(.DW(PW)) u_count (
        .clk   (CLK),
        .rst_n (RSTn),
        .dnxt  (count_nxt),
        .qout  (count)
    );

    // Shadow flag: front-end flush opens it, back-end flush closes it and wins a tie.
    gen_rsffr #(.DW(1)) u_mispredict (
        .clk    (CLK),
        .rst_n  (RSTn),
        .set_in (feflush & ~beflush),
        .rst_in (beflush),
        .qout   (isMisPredict)
    );

    // Storage is never cleared; only the pointers define what is live.
    always_ff @(posedge CLK) begin
        if (RSTn && push_en) begin
            for (int i = 0; i < PUSH_W; i++) begin
                if (push_valid[i]) begin
                    mem[AW'((int'(wr_ptr) + i) % DEPTH)] <= push_data[i*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        entries = '0;
        for (int e = 0; e < DEPTH; e++) begin
            entries[e*DW +: DW] = mem[e];
        end
    end

    queue_lane_sel #(
        .DW    (DW),
        .AW    (AW),
        .LANES (POP_W)
    ) u_pop_sel (
        .entries (entries),
        .base    (rd_ptr),
        .lanes   (pop_data)
    );

    always_comb begin
        pop_valid = '0;
        for (int i = 0; i < POP_W; i++) begin
            pop_valid[i] = (PW'(i) < count) & ~isMisPredict;
        end
    end

endmodule

// File: tb/tb_instr_queue_mw.sv
// Directed bench for instr_queue_mw with a queue-based reference model checked every cycle.
module tb_instr_queue_mw;

    localparam int DW     = 32;
    localparam int AW     = 3;
    localparam int DEPTH  = 8;
    localparam int PUSH_W = 2;
    localparam int POP_W  = 2;

    logic                 CLK;
    logic                 RSTn;
    logic [PUSH_W-1:0]    push_valid;
    logic [PUSH_W*DW-1:0] push_data;
    logic                 push_reject;
    logic [POP_W-1:0]     pop_valid;
    logic [POP_W*DW-1:0]  pop_data;
    logic [1:0]           pop_cnt;
    logic                 feflush;
    logic                 beflush;
    logic                 isMisPredict;
    logic [AW:0]          count;

    instr_queue_mw #(
        .DW     (DW),
        .AW     (AW),
        .PUSH_W (PUSH_W),
        .POP_W  (POP_W)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .push_valid   (push_valid),
        .push_data    (push_data),
        .push_reject  (push_reject),
        .pop_valid    (pop_valid),
        .pop_data     (pop_data),
        .pop_cnt      (pop_cnt),
        .feflush      (feflush),
        .beflush      (beflush),
        .isMisPredict (isMisPredict),
        .count        (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the queue contents in order, plus the shadow flag.
    logic [DW-1:0] mq[$];
    bit            mis_m  = 1'b0;
    bit            cmp_en = 1'b0;

    always @(posedge CLK) begin
        bit rej;
        rej = 1'b0;
        if (!RSTn) begin
            mq.delete();
            mis_m = 1'b0;
        end else if (feflush || beflush) begin
            mq.delete();
            mis_m = beflush ? 1'b0 : 1'b1;
        end else begin
            rej = (DEPTH - mq.size()) < PUSH_W;
            if (!mis_m) begin
                for (int k = 0; k < int'(pop_cnt); k++) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                end
            end
            if (!rej) begin
                for (int k = 0; k < PUSH_W; k++) begin
                    if (push_valid[k]) mq.push_back(push_data[k*DW +: DW]);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("count", count, mq.size());
            check("push_reject", push_reject, (DEPTH - mq.size()) < PUSH_W);
            check("isMisPredict", isMisPredict, mis_m);
            for (int i = 0; i < POP_W; i++) begin
                bit ev;
                ev = (i < mq.size()) && !mis_m;
                check($sformatf("pop_valid[%0d]", i), pop_valid[i], ev);
                if (ev) check($sformatf("pop_data[%0d]", i), pop_data[i*DW +: DW], mq[i]);
            end
        end
    end

    always @(negedge CLK) begin
        if (RSTn) begin
            assert (push_valid != 2'b10) else $error("push_valid is not thermometer coded");
            if (!isMisPredict && !feflush && !beflush)
                assert (int'(pop_cnt) <= $countones(pop_valid)) else $error("pop_cnt exceeds visible entries");
        end
    end

    logic [DW-1:0] seq = 32'hA000_0000;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_push(input logic [PUSH_W-1:0] vld);
        push_valid = vld;
        push_data  = {seq + 32'd1, seq};
        seq        = seq + 32'd2;
    endtask

    initial begin
        RSTn       = 1'b0;
        push_valid = '0;
        push_data  = '0;
        pop_cnt    = '0;
        feflush    = 1'b0;
        beflush    = 1'b0;
        step();
        step();
        cmp_en = 1'b1;
        check("rst_count", count, 0);
        check("rst_push_reject", push_reject, 0);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_mispredict", isMisPredict, 0);
        RSTn = 1'b1;

        // Fill with two lanes per cycle, then one dropped push while full.
        for (int c = 0; c < 4; c++) begin
            drive_push(2'b11);
            step();
        end
        check("t1_count", count, 8);
        check("t1_reject", push_reject, 1);
        drive_push(2'b11);
        step();
        check("t1_drop_count", count, 8);
        check("t1_head", pop_data[DW-1:0], 32'hA000_0000);

        // Drain to 2, then steady push 2 / pop 2 across five pointer wraps.
        push_valid = '0;
        pop_cnt    = 2'd2;
        for (int c = 0; c < 3; c++) step();
        check("t2_pre_count", count, 2);
        check("t2_pre_head", pop_data[DW-1:0], 32'hA000_0006);
        for (int c = 0; c < 20; c++) begin
            drive_push(2'b11);
            step();
        end
        check("t2_count", count, 2);
        check("t2_head", pop_data[DW-1:0], 32'hA000_0030);
        check("t2_lane1", pop_data[2*DW-1:DW], 32'hA000_0031);

        // Build occupancy 7, then push 2 + pop 2 together.
        pop_cnt = '0;
        drive_push(2'b11);
        step();
        drive_push(2'b11);
        step();
        drive_push(2'b01);
        step();
        check("t3_count7", count, 7);
        check("t3_reject", push_reject, 1);
        drive_push(2'b11);
        pop_cnt = 2'd2;
        step();
        check("t3_count5", count, 5);

        // Front-end flush opens the shadow; pushes land, pops are ignored.
        push_valid = '0;
        pop_cnt    = '0;
        feflush    = 1'b1;
        step();
        feflush = 1'b0;
        check("t4_count", count, 0);
        check("t4_mispredict", isMisPredict, 1);
        check("t4_pop_valid", pop_valid, 0);
        pop_cnt = 2'd2;
        for (int c = 0; c < 2; c++) begin
            drive_push(2'b11);
            step();
        end
        check("t4_count_after_push", count, 4);
        check("t4_pop_valid_hidden", pop_valid, 0);

        // Both flushes together: back-end flush wins and closes the shadow.
        push_valid = '0;
        pop_cnt    = '0;
        feflush    = 1'b1;
        beflush    = 1'b1;
        step();
        feflush = 1'b0;
        beflush = 1'b0;
        check("t5_mispredict", isMisPredict, 0);
        check("t5_count", count, 0);
        drive_push(2'b11);
        step();
        check("t5_visible", pop_valid, 2'b11);

        // Reset mid-stream with occupancy 6, shadow set and a push pending.
        push_valid = '0;
        feflush    = 1'b1;
        step();
        feflush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_push(2'b11);
            step();
        end
        check("t6_pre_count", count, 6);
        check("t6_pre_mispredict", isMisPredict, 1);
        RSTn = 1'b0;
        drive_push(2'b11);
        step();
        check("t6_count", count, 0);
        check("t6_pop_valid", pop_valid, 0);
        check("t6_push_reject", push_reject, 0);
        check("t6_mispredict", isMisPredict, 0);
        RSTn       = 1'b1;
        push_valid = '0;
        step();
        step();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
